mdio_master: RTL

- MDIO station-management initiator (Clause 22): the controller side that drives MDC and issues read/write frames to a PHY.
- Counterpart of the team's PHY-side MDIO responder; the bench connects the two back-to-back.
- Accepts one register transaction per valid/ready handshake, serialises it onto MDIO, and returns read data with a completion pulse.

---
 rtl/mdio_pkg.sv | 51 +++++
 rtl/mdio_clk_gen.sv | 45 ++++
 rtl/mdio_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants, state encoding and field helpers for the
// Clause 22 MDIO initiator (and the responder bench that reuses them).
package mdio_pkg;

    localparam logic [1:0] MDIO_START    = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

    localparam int PHY_ADDR_W = 5;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 16;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_START    = 4'd2,
        ST_OPCODE   = 4'd3,
        ST_PHY_ADDR = 4'd4,
        ST_REG_ADDR = 4'd5,
        ST_TA       = 4'd6,
        ST_DATA     = 4'd7,
        ST_DONE     = 4'd8
    } mdio_state_t;

    // Index of the first (MSB) bit of a fixed-width field; the shared bit
    // counter is loaded with this on entry and counts down to 0.
    function automatic logic [5:0] field_last_bit(input mdio_state_t s);
        case (s)
            ST_START, ST_OPCODE, ST_TA: field_last_bit = 6'd1;
            ST_PHY_ADDR:                field_last_bit = 6'(PHY_ADDR_W - 1);
            ST_REG_ADDR:                field_last_bit = 6'(REG_ADDR_W - 1);
            ST_DATA:                    field_last_bit = 6'(DATA_W - 1);
            default:                    field_last_bit = 6'd0;
        endcase
    endfunction

    function automatic mdio_state_t field_next(input mdio_state_t s);
        case (s)
            ST_PREAMBLE: field_next = ST_START;
            ST_START:    field_next = ST_OPCODE;
            ST_OPCODE:   field_next = ST_PHY_ADDR;
            ST_PHY_ADDR: field_next = ST_REG_ADDR;
            ST_REG_ADDR: field_next = ST_TA;
            ST_TA:       field_next = ST_DATA;
            ST_DATA:     field_next = ST_DONE;
            default:     field_next = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC divider. While i_run is high the counter runs
// 0..CLK_DIV-1 and o_mdc toggles on each wrap (bit period 2*CLK_DIV).
// When i_run is low the counter and MDC are held at 0.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_run            : frame active
//   o_mdc            : management clock (idles low)
//   o_fall_tick      : high in the cycle whose closing edge drops MDC
//   o_rise_tick      : high in the cycle whose closing edge raises MDC
module mdio_clk_gen #(
    parameter int CLK_DIV = 6
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_run,
    output logic o_mdc,
    output logic o_fall_tick,
    output logic o_rise_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap        = i_run && (cnt_q == CNT_MAX);
    assign o_fall_tick = wrap && o_mdc;
    assign o_rise_tick = wrap && !o_mdc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
            o_mdc <= 1'b0;
        end else if (!i_run) begin
            cnt_q <= '0;
            o_mdc <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            o_mdc <= !o_mdc;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO station-management initiator.
// Accepts one read/write request per valid/ready handshake, serialises the
// frame on MDIO (drive at bit start, sample on MDC rise) and reports read
// data with a one-cycle completion pulse.
//   i_clk, i_reset_n        : clock, async active-low reset
//   i_req_valid/o_req_ready : request handshake (ready only in IDLE)
//   i_req_write             : 1 = write, 0 = read
//   i_phy_addr, i_reg_addr  : 5-bit PHY / register address
//   i_wdata                 : write data
//   o_rdata                 : read data, held until the next read completes
//   o_done                  : end-of-frame pulse
//   o_rd_err                : read TA second bit sampled high (no PHY)
//   o_mdc                   : management clock
//   o_mdio_o, o_mdio_oe     : MDIO output value / enable (tristate is outside)
//   i_mdio_i                : MDIO pad input
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 6,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_done,
    output logic        o_rd_err,
    output logic        o_mdc,
    output logic        o_mdio_o,
    output logic        o_mdio_oe,
    input  logic        i_mdio_i
);

    localparam logic [5:0] PRE_LAST =
        6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    mdio_state_t state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        advance;
    logic        accept;
    logic        run;
    logic        fall_tick, rise_tick;
    logic        mdo_d, oe_d;

    logic        write_q;
    logic [4:0]  phy_q, reg_q;
    logic [15:0] wdata_q;
    logic [15:0] rx_shift_q;
    logic        ta_err_q;

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign accept      = i_req_valid && (state_q == ST_IDLE);
    assign run         = (state_q != ST_IDLE) && (state_q != ST_DONE);

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_run       (run),
        .o_mdc       (o_mdc),
        .o_fall_tick (fall_tick),
        .o_rise_tick (rise_tick)
    );

    // Next state / bit counter. "advance" marks every edge that starts a new
    // bit: the acceptance edge (first bit) and each MDC fall during a frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        advance   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    advance = 1'b1;
                    if (PREAMBLE_LEN > 0) begin
                        state_d   = ST_PREAMBLE;
                        bit_cnt_d = PRE_LAST;
                    end else begin
                        state_d   = ST_START;
                        bit_cnt_d = field_last_bit(ST_START);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (fall_tick) begin
                    advance = 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d   = field_next(state_q);
                        bit_cnt_d = field_last_bit(state_d);
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end
        endcase
    end

    // Value driven for the bit that starts at the next edge. The first bit is
    // always preamble or START, so it never needs the not-yet-latched request.
    always_comb begin
        mdo_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            ST_PREAMBLE: begin
                mdo_d = 1'b1;
                oe_d  = 1'b1;
            end
            ST_START: begin
                mdo_d = MDIO_START[bit_cnt_d[0]];
                oe_d  = 1'b1;
            end
            ST_OPCODE: begin
                mdo_d = write_q ? MDIO_OP_WRITE[bit_cnt_d[0]]
                                : MDIO_OP_READ[bit_cnt_d[0]];
                oe_d  = 1'b1;
            end
            ST_PHY_ADDR: begin
                mdo_d = phy_q[bit_cnt_d[2:0]];
                oe_d  = 1'b1;
            end
            ST_REG_ADDR: begin
                mdo_d = reg_q[bit_cnt_d[2:0]];
                oe_d  = 1'b1;
            end
            ST_TA: begin
                if (write_q) begin
                    mdo_d = MDIO_TA_WRITE[bit_cnt_d[0]];
                    oe_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (write_q) begin
                    mdo_d = wdata_q[bit_cnt_d[3:0]];
                    oe_d  = 1'b1;
                end
            end
            default: begin
                mdo_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_mdio_o  <= 1'b1;
            o_mdio_oe <= 1'b0;
        end else if (advance) begin
            o_mdio_o  <= mdo_d;
            o_mdio_oe <= oe_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            write_q    <= 1'b0;
            phy_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            rx_shift_q <= '0;
            ta_err_q   <= 1'b0;
            o_rdata    <= '0;
            o_rd_err   <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= i_req_write;
                phy_q    <= i_phy_addr;
                reg_q    <= i_reg_addr;
                wdata_q  <= i_wdata;
                o_rd_err <= 1'b0;
            end
            if (rise_tick && (state_q == ST_TA) && (bit_cnt_q == '0)) begin
                ta_err_q <= i_mdio_i;
            end
            if (rise_tick && (state_q == ST_DATA)) begin
                rx_shift_q <= {rx_shift_q[14:0], i_mdio_i};
            end
            // Results land on the DATA->DONE edge so they appear with o_done.
            if ((state_q == ST_DATA) && (state_d == ST_DONE) && !write_q) begin
                o_rdata  <= rx_shift_q;
                o_rd_err <= ta_err_q;
            end
        end
    end

endmodule
